jk_pair_exerciser: RTL and testbench
====================================

Name: jk_pair_exerciser

Overview:
- Self-checking stimulus/response engine for a dual negative-edge JK flip-flop with active-low preset/clear (HC112-style pin behaviour).
- Drives S_N/R_N/J/K and a generated DUT clock to both channels of the flop pair, and samples Q/Q_N back.
- Compares the sampled outputs against an internal golden model, then reports an error count and a pass/fail verdict.
- Synthesizable, so the same exerciser serves in simulation and on the board as the driving end of the flop interface.

Parameters:
- NUM_VECTORS, 20, vectors applied per run (1..65535).
- LFSR_SEED, 16'hACE1, non-zero LFSR load value on reset/Start.
- ERR_W, 8, error counter width; the counter saturates at all-ones.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high.
- Start  input  1  single-cycle run request; sampled only in IDLE.
- Dut_Clk  output  1  generated clock to the DUT (the DUT captures on its falling edge).
- S1_N, R1_N, J1, K1  output  1 each  channel-1 drive.
- S2_N, R2_N, J2, K2  output  1 each  channel-2 drive.
- Q1, Q1_N, Q2, Q2_N  input  1 each  DUT outputs.
- Busy  output  1  high while a run is active.
- Done  output  1  high from run end until the next accepted Start.
- Pass  output  1  valid while Done is high; 1 when Err_Count==0.
- Err_Count  output  ERR_W  mismatching vectors, saturating.
- Vec_Count  output  16  vectors completed in the current run.

Behaviour:
Reset:
- State=IDLE; Dut_Clk=1.
- All S*_N and R*_N = 1; all J*, K* = 0.
- Busy=0, Done=0, Pass=0, Err_Count=0, Vec_Count=0.
- LFSR=LFSR_SEED; golden Q1=Q2=0 (expected Q_N=1).

LFSR:
- 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifted once per vector at CHECK exit.
- Bit mapping:
  - J1=b0, K1=b1, J2=b2, K2=b3.
  - S1_N=~(b5:b4==00), R1_N=~(b7:b6==00).
  - S2_N=~(b9:b8==00), R2_N=~(b11:b10==00).

FSM: IDLE -> SETUP -> EDGE -> SETTLE -> CHECK -> (SETUP | DONE). Each vector takes 4 cycles.
- IDLE:
  - Start=1 clears Err_Count, Vec_Count, Done and Pass, reloads LFSR=LFSR_SEED, and enters SETUP.
  - Golden state is not reset by Start.
- SETUP: outputs driven from the LFSR; Dut_Clk=1; Busy=1.
- EDGE:
  - Dut_Clk=0 (falling edge to the DUT); drive held.
  - Golden model updates per channel:
    - If S_N=1 and R_N=1: JK 00 hold, 01 Q=0, 10 Q=1, 11 toggle.
    - Otherwise the edge is ignored.
- SETTLE: Dut_Clk=0; drive held; no sampling.
- CHECK:
  - Dut_Clk returns to 1; drive held; DUT Q/Q_N sampled.
  - Expected values per channel:
    - S_N=0, R_N=1: Q=1, Q_N=0; golden Q set to 1.
    - S_N=1, R_N=0: Q=0, Q_N=1; golden Q set to 0.
    - S_N=0, R_N=0: Q=1, Q_N=1; golden Q is unchanged (indeterminate afterward, treated as the last stored value).
    - Otherwise: Q=golden, Q_N=~golden.
  - Any mismatch on any of the 4 bits counts one error per vector; Err_Count saturates.
  - Vec_Count increments.
  - If Vec_Count reaches NUM_VECTORS, go to DONE; else shift the LFSR and go to SETUP.
- DONE: Busy=0, Done=1, Pass=(Err_Count==0); drive returns to the reset values; next state IDLE, with Done/Pass held.

Boundary conditions:
- Start while Busy: ignored.
- Reset mid-run: immediate return to the reset values at the next Clk edge; no partial verdict.
- Start and Reset in the same cycle: Reset wins.
- Timing: with Start accepted at cycle t, Done rises at cycle t+4*NUM_VECTORS+1.

Optional Feature:
- Macro JK_EXERCISER_STOP_ON_FAIL_EN.
- Defined: the first mismatch at CHECK goes directly to DONE with Err_Count=1, Pass=0, and Vec_Count including the failing vector.
- Undefined: all NUM_VECTORS vectors run regardless of errors.

Test Plan:
- Reset held 3 cycles -> Dut_Clk=1, all S*_N/R*_N=1, J*/K*=0, Busy=Done=Pass=0, counts 0.
- Correct HC112 model attached, NUM_VECTORS=20, Start pulse at t -> Busy t+1..t+80, Done=1 at t+81, Vec_Count=20, Err_Count=0, Pass=1.
- Q1 forced 0, Q1_N forced 1 -> Err_Count equals the number of vectors expecting Q1=1 (nonzero for seed ACE1), Pass=0; with JK_EXERCISER_STOP_ON_FAIL_EN, Err_Count=1 and Vec_Count equals the index of the first such vector.
- Directed LFSR_SEED with b5:b4=00 and b7:b6=00 on vector 1 -> expect Q1=Q1_N=1; a DUT returning Q1_N=0 yields Err_Count=1.
- Reset asserted at vector 7 SETTLE -> next cycle IDLE with all outputs at reset values; a new Start gives a fresh 20-vector run from LFSR_SEED.
- Start pulsed again while Busy -> ignored, run length unchanged (Done at t+81).

Source files
------------

// File: rtl/jk_pair_exerciser.sv
// Stimulus/response engine for a dual negative-edge JK flop pair with async preset/clear.
// Optional build macro JK_EXERCISER_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
`timescale 1ns/1ps
module jk_pair_exerciser #(
    parameter int          NUM_VECTORS = 20,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          ERR_W       = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    output logic             Dut_Clk,
    output logic             S1_N,
    output logic             R1_N,
    output logic             J1,
    output logic             K1,
    output logic             S2_N,
    output logic             R2_N,
    output logic             J2,
    output logic             K2,
    input  logic             Q1,
    input  logic             Q1_N,
    input  logic             Q2,
    input  logic             Q2_N,
    output logic             Busy,
    output logic             Done,
    output logic             Pass,
    output logic [ERR_W-1:0] Err_Count,
    output logic [15:0]      Vec_Count
);

    // Drive vector layout: {S1_N, R1_N, J1, K1, S2_N, R2_N, J2, K2}
    localparam logic [7:0] DRV_IDLE = 8'b1100_1100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EDGE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_lfsr;
    logic [15:0]      r_vec;
    logic [7:0]       r_drv;
    logic             r_dut_clk;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_gq1;
    logic             r_gq2;
    logic [ERR_W-1:0] r_err;

    logic [15:0]      w_lfsr_shift;
    logic [15:0]      w_vec_inc;
    logic [1:0]       w_exp1;
    logic [1:0]       w_exp2;
    logic             w_mismatch;
    logic             w_end;
    logic [ERR_W-1:0] w_err_nxt;

    function automatic logic [7:0] drive_of(input logic [15:0] v);
        return {|v[5:4], |v[7:6], v[0], v[1], |v[9:8], |v[11:10], v[2], v[3]};
    endfunction

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        case ({j, k})
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            2'b11:   return ~q;
            default: return q;
        endcase
    endfunction

    // Expected {Q, Q_N}; both async inputs low drives both outputs high.
    function automatic logic [1:0] expect_q(input logic s_n, input logic r_n, input logic gq);
        case ({s_n, r_n})
            2'b01:   return 2'b10;
            2'b10:   return 2'b01;
            2'b00:   return 2'b11;
            default: return {gq, ~gq};
        endcase
    endfunction

    function automatic logic async_q(input logic s_n, input logic r_n, input logic gq);
        case ({s_n, r_n})
            2'b01:   return 1'b1;
            2'b10:   return 1'b0;
            default: return gq;
        endcase
    endfunction

    always_comb begin
        w_lfsr_shift = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
        w_vec_inc    = r_vec + 16'd1;
        w_exp1       = expect_q(r_drv[7], r_drv[6], r_gq1);
        w_exp2       = expect_q(r_drv[3], r_drv[2], r_gq2);
        w_mismatch   = ({Q1, Q1_N} != w_exp1) || ({Q2, Q2_N} != w_exp2);
        w_err_nxt    = (w_mismatch && (r_err != '1)) ? r_err + 1'b1 : r_err;
`ifdef JK_EXERCISER_STOP_ON_FAIL_EN
        w_end        = (w_vec_inc == 16'(NUM_VECTORS)) || w_mismatch;
`else
        w_end        = (w_vec_inc == 16'(NUM_VECTORS));
`endif
        w_state_nxt  = r_state;
        case (r_state)
            ST_IDLE:   if (Start) w_state_nxt = ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_EDGE;
            ST_EDGE:   w_state_nxt = ST_SETTLE;
            ST_SETTLE: w_state_nxt = ST_CHECK;
            ST_CHECK:  w_state_nxt = w_end ? ST_DONE : ST_SETUP;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_lfsr    <= LFSR_SEED;
            r_vec     <= '0;
            r_drv     <= DRV_IDLE;
            r_dut_clk <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_gq1     <= 1'b0;
            r_gq2     <= 1'b0;
            r_err     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_lfsr    <= LFSR_SEED;
                        r_vec     <= '0;
                        r_err     <= '0;
                        r_done    <= 1'b0;
                        r_pass    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_drv     <= drive_of(LFSR_SEED);
                        r_dut_clk <= 1'b1;
                    end
                end
                ST_SETUP:  r_dut_clk <= 1'b0;
                ST_EDGE: begin
                    // The DUT saw its falling edge on entry; clocked update only with presets released
                    if (r_drv[7] && r_drv[6]) r_gq1 <= jk_next(r_gq1, r_drv[5], r_drv[4]);
                    if (r_drv[3] && r_drv[2]) r_gq2 <= jk_next(r_gq2, r_drv[1], r_drv[0]);
                end
                ST_SETTLE: r_dut_clk <= 1'b1;
                ST_CHECK: begin
                    r_vec <= w_vec_inc;
                    r_err <= w_err_nxt;
                    r_gq1 <= async_q(r_drv[7], r_drv[6], r_gq1);
                    r_gq2 <= async_q(r_drv[3], r_drv[2], r_gq2);
                    if (w_end) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (w_err_nxt == '0);
                        r_drv  <= DRV_IDLE;
                    end else begin
                        r_lfsr <= w_lfsr_shift;
                        r_drv  <= drive_of(w_lfsr_shift);
                    end
                end
                default: ;
            endcase
        end
    end

    assign Dut_Clk   = r_dut_clk;
    assign {S1_N, R1_N, J1, K1, S2_N, R2_N, J2, K2} = r_drv;
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Pass      = r_pass;
    assign Err_Count = r_err;
    assign Vec_Count = r_vec;

endmodule

// File: tb/tb_jk_pair_exerciser.sv
// Directed bench for jk_pair_exerciser: a behavioural HC112-style pair on the main instance,
// and a one-vector instance with a preset+clear seed driven by tied responses.
`timescale 1ns/1ps
module tb_jk_pair_exerciser;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic rst2 = 1'b1;
    logic start2 = 1'b0;
    logic f1 = 1'b0;
    logic f2 = 1'b0;

    always #5 clk = ~clk;

    logic       d_clk, s1n, r1n, j1, k1, s2n, r2n, j2, k2;
    logic       busy, done, pass;
    logic [7:0] err;
    logic [15:0] vec;
    logic       q1i, q1ni, q2i, q2ni;
    logic [7:0] drv1;

    logic       b_dclk, b_s1n, b_r1n, b_j1, b_k1, b_s2n, b_r2n, b_j2, b_k2;
    logic       b_busy, b_done, b_pass;
    logic [7:0] b_err;
    logic [15:0] b_vec;
    logic       b_q1n;
    logic [7:0] drv2;

    logic m1q = 1'b0;
    logic m2q = 1'b0;
    logic m1_qo, m1_qno, m2_qo, m2_qno;
    int   n_q1_hi = 0;
    int   n_checks = 0;
    int   n_errs = 0;

    jk_pair_exerciser #(.NUM_VECTORS(20), .LFSR_SEED(16'hACE1), .ERR_W(8)) u_dut (
        .Clk(clk), .Reset(rst), .Start(start), .Dut_Clk(d_clk),
        .S1_N(s1n), .R1_N(r1n), .J1(j1), .K1(k1),
        .S2_N(s2n), .R2_N(r2n), .J2(j2), .K2(k2),
        .Q1(q1i), .Q1_N(q1ni), .Q2(q2i), .Q2_N(q2ni),
        .Busy(busy), .Done(done), .Pass(pass), .Err_Count(err), .Vec_Count(vec)
    );

    jk_pair_exerciser #(.NUM_VECTORS(1), .LFSR_SEED(16'hFF0F), .ERR_W(8)) u_seed (
        .Clk(clk), .Reset(rst2), .Start(start2), .Dut_Clk(b_dclk),
        .S1_N(b_s1n), .R1_N(b_r1n), .J1(b_j1), .K1(b_k1),
        .S2_N(b_s2n), .R2_N(b_r2n), .J2(b_j2), .K2(b_k2),
        .Q1(1'b1), .Q1_N(b_q1n), .Q2(1'b1), .Q2_N(1'b0),
        .Busy(b_busy), .Done(b_done), .Pass(b_pass), .Err_Count(b_err), .Vec_Count(b_vec)
    );

    assign drv1  = {s1n, r1n, j1, k1, s2n, r2n, j2, k2};
    assign drv2  = {b_s1n, b_r1n, b_j1, b_k1, b_s2n, b_r2n, b_j2, b_k2};
    assign b_q1n = ~f2;

    function automatic logic jk(input logic q, input logic j, input logic k);
        case ({j, k})
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            2'b11:   return ~q;
            default: return q;
        endcase
    endfunction

    // Behavioural dual flop: async preset/clear, capture on falling clock
    always @(negedge d_clk, negedge s1n, posedge s1n, negedge r1n, posedge r1n) begin
        if (!s1n && r1n)                 m1q <= 1'b1;
        else if (s1n && !r1n)            m1q <= 1'b0;
        else if (s1n && r1n && !d_clk)   m1q <= jk(m1q, j1, k1);
    end

    always @(negedge d_clk, negedge s2n, posedge s2n, negedge r2n, posedge r2n) begin
        if (!s2n && r2n)                 m2q <= 1'b1;
        else if (s2n && !r2n)            m2q <= 1'b0;
        else if (s2n && r2n && !d_clk)   m2q <= jk(m2q, j2, k2);
    end

    assign m1_qo  = !s1n ? 1'b1 : (!r1n ? 1'b0 : m1q);
    assign m1_qno = !r1n ? 1'b1 : (!s1n ? 1'b0 : ~m1q);
    assign m2_qo  = !s2n ? 1'b1 : (!r2n ? 1'b0 : m2q);
    assign m2_qno = !r2n ? 1'b1 : (!s2n ? 1'b0 : ~m2q);

    assign q1i  = m1_qo & ~f1;
    assign q1ni = m1_qno | f1;
    assign q2i  = m2_qo;
    assign q2ni = m2_qno;

    // Tally of checkpoints at which a healthy flop presents Q1=1
    always @(posedge d_clk) begin
        if (m1_qo) n_q1_hi <= n_q1_hi + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int base_hi;
        int exp_err;

        ticks(3);
        check_eq("rst_dclk", d_clk, 1);
        check_eq("rst_drive", drv1, 8'hCC);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pass", pass, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_vec", vec, 0);
        rst  = 1'b0;
        rst2 = 1'b0;
        tick();

        // Run 1: healthy flop, second Start mid-run
        start = 1'b1; tick(); start = 1'b0;
        check_eq("r1_busy_t1", busy, 1);
        check_eq("r1_drive_v1", drv1, 8'hE4);
        check_eq("r1_dclk_setup", d_clk, 1);
        tick();
        check_eq("r1_dclk_edge", d_clk, 0);
        ticks(3);
        check_eq("r1_drive_v2", drv1, 8'hCC);
        check_eq("r1_vec_after_v1", vec, 1);
        ticks(5);
        start = 1'b1; tick(); start = 1'b0;
        ticks(69);
        check_eq("r1_busy_t80", busy, 1);
        check_eq("r1_done_t80", done, 0);
        check_eq("r1_vec_t80", vec, 19);
        tick();
        check_eq("r1_done_t81", done, 1);
        check_eq("r1_busy_t81", busy, 0);
        check_eq("r1_pass", pass, 1);
        check_eq("r1_err", err, 0);
        check_eq("r1_vec", vec, 20);
        check_eq("r1_drive_idle", drv1, 8'hCC);
        ticks(3);
        check_eq("r1_done_held", done, 1);
        check_eq("r1_pass_held", pass, 1);

        // Run 2: Q1 stuck low, Q1_N stuck high
        f1 = 1'b1;
        base_hi = n_q1_hi;
        start = 1'b1; tick(); start = 1'b0;
        check_eq("r2_done_cleared", done, 0);
        for (int i = 0; i < 200 && !done; i++) tick();
        check_eq("r2_done", done, 1);
        check_eq("r2_pass", pass, 0);
        check_eq("r2_err_nonzero", (err != 8'd0), 1);
`ifdef JK_EXERCISER_STOP_ON_FAIL_EN
        check_eq("r2_err", err, 1);
        check_eq("r2_vec", vec, 1);
`else
        exp_err = n_q1_hi - base_hi;
        check_eq("r2_err", err, exp_err);
        check_eq("r2_vec", vec, 20);
`endif
        f1 = 1'b0;
        tick();

        // Reset and Start together: Reset wins
        rst = 1'b1; start = 1'b1; tick();
        rst = 1'b0; start = 1'b0;
        check_eq("rs_busy", busy, 0);
        check_eq("rs_done", done, 0);
        check_eq("rs_err", err, 0);
        tick();
        check_eq("rs_busy_after", busy, 0);

        // Run 3: reset during vector 7 SETTLE, then a fresh run
        start = 1'b1; tick(); start = 1'b0;
        ticks(26);
        check_eq("r3_dclk_settle", d_clk, 0);
        check_eq("r3_vec_v7", vec, 6);
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("r3_rst_dclk", d_clk, 1);
        check_eq("r3_rst_drive", drv1, 8'hCC);
        check_eq("r3_rst_busy", busy, 0);
        check_eq("r3_rst_done", done, 0);
        check_eq("r3_rst_vec", vec, 0);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        check_eq("r3_drive_v1", drv1, 8'hE4);
        ticks(80);
        check_eq("r3_done", done, 1);
        check_eq("r3_err", err, 0);
        check_eq("r3_vec", vec, 20);
        check_eq("r3_pass", pass, 1);

        // Seed FF0F: vector 1 holds preset and clear low on channel 1
        start2 = 1'b1; tick(); start2 = 1'b0;
        check_eq("s_drive_v1", drv2, 8'h3F);
        check_eq("s_busy", b_busy, 1);
        ticks(3);
        check_eq("s_done_t4", b_done, 0);
        tick();
        check_eq("s_done_t5", b_done, 1);
        check_eq("s_err_ok", b_err, 0);
        check_eq("s_pass_ok", b_pass, 1);
        check_eq("s_vec", b_vec, 1);
        rst2 = 1'b1; tick(); rst2 = 1'b0;
        f2 = 1'b1;
        start2 = 1'b1; tick(); start2 = 1'b0;
        ticks(4);
        check_eq("s_bad_done", b_done, 1);
        check_eq("s_bad_err", b_err, 1);
        check_eq("s_bad_pass", b_pass, 0);
        f2 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
